// File: rtl/pmem_loader.sv
// Program memory with a byte-serial loader: bytes are packed little-endian into words and written
// sequentially while instruction fetches are blocked. Define PMEM_OUTREG_EN for a second output stage.
module pmem_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RDEN,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DO,
    output logic              DO_VALID,
    input  logic              PGM_START,
    input  logic [ADDR_W-1:0] PGM_ADDR,
    input  logic [7:0]        PGM_BYTE,
    input  logic              PGM_VALID,
    input  logic              PGM_LAST,
    output logic              PGM_READY,
    output logic              BUSY,
    output logic              PGM_DONE,
    output logic [1:0]        DBG_STATE
);
    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_asm;
    logic              r_last;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic w_accept;
    logic w_word_full;
    logic w_fetch;

    // Handshake: a byte transfers on a rising edge where PGM_VALID and PGM_READY are both high;
    // PGM_READY is high only in LOAD, so the byte must be held until that edge.
    assign w_accept    = (r_state == S_LOAD) && PGM_VALID;
    assign w_word_full = (r_cnt == CNT_W'(BYTES - 1));
    assign w_fetch     = RDEN && (r_state == S_IDLE);

    assign PGM_READY = (r_state == S_LOAD);
    assign BUSY      = (r_state != S_IDLE);
    assign PGM_DONE  = (r_state == S_DONE);
    assign DBG_STATE = r_state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (PGM_START) begin
                        r_wptr  <= PGM_ADDR;
                        r_cnt   <= '0;
                        r_asm   <= '0;
                        r_last  <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        for (int k = 0; k < BYTES; k++) begin
                            if (r_cnt == CNT_W'(k)) begin
                                r_asm[8*k +: 8] <= PGM_BYTE;
                            end
                        end
                        if (w_word_full || PGM_LAST) begin
                            r_cnt   <= '0;
                            r_last  <= PGM_LAST;
                            r_state <= S_WRITE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // Clearing the assembly register here gives zero padding for a short final word.
                    r_wptr  <= r_wptr + 1'b1;
                    r_asm   <= '0;
                    r_state <= r_last ? S_DONE : S_LOAD;
                end
                S_DONE: begin
                    r_last  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The array has no reset so it maps onto block RAM and survives RST.
    always_ff @(posedge CLK) begin
        if (!RST && (r_state == S_WRITE)) begin
            r_mem[r_wptr] <= r_asm;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_fetch;
            if (w_fetch) begin
                r_rd_data <= r_mem[ADDR];
            end
        end
    end

`ifdef PMEM_OUTREG_EN
    logic [DATA_W-1:0] r_do2;
    logic              r_do2_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_do2       <= '0;
            r_do2_valid <= 1'b0;
        end else begin
            r_do2_valid <= r_rd_valid;
            if (r_rd_valid) begin
                r_do2 <= r_rd_data;
            end
        end
    end

    assign DO       = r_do2;
    assign DO_VALID = r_do2_valid;
`else
    assign DO       = r_rd_data;
    assign DO_VALID = r_rd_valid;
`endif

endmodule

// File: tb/tb_pmem_loader.sv
// Self-checking bench for pmem_loader: directed sessions, a fetch vector table and randomized
// sessions/fetch streams checked against a word-level memory model.
module tb_pmem_loader;
`ifdef PMEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int BYTES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rden;
    logic [9:0]  addr;
    logic [15:0] do_w;
    logic        do_valid;
    logic        pgm_start;
    logic [9:0]  pgm_addr;
    logic [7:0]  pgm_byte;
    logic        pgm_valid;
    logic        pgm_last;
    logic        pgm_ready;
    logic        busy;
    logic        pgm_done;
    logic [1:0]  dbg_state;

    pmem_loader #(.ADDR_W(10), .DATA_W(16)) dut (
        .CLK(clk), .RST(rst), .RDEN(rden), .ADDR(addr), .DO(do_w), .DO_VALID(do_valid),
        .PGM_START(pgm_start), .PGM_ADDR(pgm_addr), .PGM_BYTE(pgm_byte),
        .PGM_VALID(pgm_valid), .PGM_LAST(pgm_last), .PGM_READY(pgm_ready),
        .BUSY(busy), .PGM_DONE(pgm_done), .DBG_STATE(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, state=%0d", dbg_state);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] mem_m [1024];
    logic [15:0] exp_q [$];
    logic [9:0]  wr_addrs [$];
    logic [7:0]  pq [$];
    logic [15:0] last_do;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
        end
    endtask

    // Word-level effect of a session: pq bytes packed little-endian, zero padded, consecutive addresses.
    task automatic model_write(input logic [9:0] base, input int nbytes, input bit complete);
        int nwords;
        nwords = complete ? (nbytes + BYTES - 1) / BYTES : nbytes / BYTES;
        for (int w = 0; w < nwords; w++) begin
            logic [9:0] a;
            logic [7:0] lo;
            logic [7:0] hi;
            a  = 10'(int'(base) + w);
            lo = pq[2*w];
            hi = (2*w + 1 < nbytes) ? pq[2*w+1] : 8'h00;
            mem_m[a] = {hi, lo};
            wr_addrs.push_back(a);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic fetch(input logic [9:0] a, input logic [15:0] exp, input string nm);
        rden = 1'b1;
        addr = a;
        tick();
        rden = 1'b0;
        repeat (LAT - 1) tick();
        chk1({nm, "_valid"}, do_valid, 1'b1);
        chk16({nm, "_data"}, do_w, exp);
        last_do = exp;
    endtask

    task automatic pgm_session(input logic [9:0] base, input bit rand_valid, input int abort_after,
                               input bit poke, input bit co_fetch, input logic [9:0] co_addr);
        int n;
        int n_stop;
        int idx;
        int cycles;
        bit exp_ready;
        bit poked;
        bit v;
        logic [15:0] exp_co;
        n      = pq.size();
        n_stop = (abort_after > 0) ? abort_after : n;
        exp_co = mem_m[co_addr];
        pgm_start = 1'b1;
        pgm_addr  = base;
        if (co_fetch) begin
            rden = 1'b1;
            addr = co_addr;
        end
        tick();
        pgm_start = 1'b0;
        rden      = 1'b0;
        chk1("busy_after_start", busy, 1'b1);
        if (co_fetch) begin
            repeat (LAT - 1) tick();
            chk1("cofetch_valid", do_valid, 1'b1);
            chk16("cofetch_data", do_w, exp_co);
            last_do = exp_co;
        end
        idx = 0; cycles = 0; exp_ready = 1'b1; poked = 1'b0;
        while (idx < n_stop && cycles < 400) begin
            if (poke && !poked && idx == 1 && exp_ready) begin
                pgm_valid = 1'b0;
                rden      = 1'b1;
                addr      = 10'h005;
                pgm_start = 1'b1;
                pgm_addr  = 10'h300;
                repeat (3) begin
                    tick();
                    cycles++;
                    chk1("poke_do_valid", do_valid, 1'b0);
                    chk16("poke_do_hold", do_w, last_do);
                    chk1("poke_busy", busy, 1'b1);
                    chk1("poke_ready", pgm_ready, 1'b1);
                end
                rden = 1'b0;
                pgm_start = 1'b0;
                poked = 1'b1;
                continue;
            end
            v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            pgm_valid = v;
            pgm_byte  = pq[idx];
            pgm_last  = (abort_after == 0) && (idx == n - 1);
            chk1("pgm_ready", pgm_ready, exp_ready);
            tick();
            cycles++;
            if (exp_ready && v) begin
                idx++;
                exp_ready = !((idx % BYTES == 0) || (idx == n));
            end else if (!exp_ready) begin
                exp_ready = 1'b1;
            end
        end
        pgm_valid = 1'b0;
        pgm_last  = 1'b0;
        if (idx < n_stop) begin
            chk1("pgm_timeout", 1'b0, 1'b1);
            return;
        end
        if (abort_after > 0) begin
            model_write(base, n_stop, 1'b0);
            return;
        end
        chk1("last_write_ready", pgm_ready, 1'b0);
        chk1("last_write_busy", busy, 1'b1);
        tick();
        chk1("done_pulse", pgm_done, 1'b1);
        tick();
        chk1("done_end", pgm_done, 1'b0);
        chk1("idle_busy", busy, 1'b0);
        model_write(base, n, 1'b1);
    endtask

    task automatic fetch_stream(input int n);
        bit vq [$];
        bit r;
        bit vv;
        logic [9:0] a;
        logic [15:0] e;
        for (int i = 0; i < n + LAT - 1; i++) begin
            r = (i < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (wr_addrs.size() > 0 && $urandom_range(0, 3) != 0)
                a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
            else
                a = 10'($urandom_range(0, 1023));
            rden = r;
            addr = a;
            if (r) exp_q.push_back(mem_m[a]);
            tick();
            vq.push_back(r);
            if (vq.size() == LAT) begin
                vv = vq.pop_front();
                chk1("stream_valid", do_valid, vv);
                if (vv) begin
                    e = exp_q.pop_front();
                    chk16("stream_data", do_w, e);
                    last_do = e;
                end else begin
                    chk16("stream_hold", do_w, last_do);
                end
            end
        end
        rden = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < 1024; i++) mem_m[i] = 16'h0000;
        last_do = 16'h0000;
        rst = 1'b1; rden = 1'b0; addr = '0; pgm_start = 1'b0; pgm_addr = '0;
        pgm_byte = '0; pgm_valid = 1'b0; pgm_last = 1'b0;
        repeat (3) tick();
        chk16("rst_do", do_w, 16'h0000);
        chk1("rst_do_valid", do_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", pgm_ready, 1'b0);
        chk1("rst_done", pgm_done, 1'b0);
        rst = 1'b0;
        tick();

        // Basic two-word session at 0x000
        pq = '{8'h05, 8'h5B, 8'hC6, 8'hA2};
        pgm_session(10'h000, 1'b0, 0, 1'b0, 1'b0, 10'h000);
        fetch(10'h000, 16'h5B05, "basic_w0");
        fetch(10'h001, 16'hA2C6, "basic_w1");

        // Wrap from 0x3FF to 0x000 with a zero-padded last word
        pq = '{8'h11, 8'h22, 8'h33};
        pgm_session(10'h3FF, 1'b0, 0, 1'b0, 1'b0, 10'h000);
        tbl[0] = '{10'h3FF, 16'h2211};
        tbl[1] = '{10'h000, 16'h0033};
        tbl[2] = '{10'h001, 16'hA2C6};
        tbl[3] = '{10'h002, 16'h0000};
        tbl[4] = '{10'h200, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            fetch(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
            chk16($sformatf("tbl%0d_model", i), mem_m[tbl[i].addr], tbl[i].exp);
        end

        // START together with a fetch in IDLE: the fetch is served
        pq = '{8'hAB, 8'hCD};
        pgm_session(10'h040, 1'b0, 0, 1'b0, 1'b1, 10'h001);
        fetch(10'h040, 16'hCDAB, "cofetch_word");

        // Fetch and START while busy are ignored
        pq = '{8'h9A, 8'hBC, 8'hDE};
        pgm_session(10'h100, 1'b0, 0, 1'b1, 1'b0, 10'h000);
        fetch(10'h100, 16'hBC9A, "poke_w0");
        fetch(10'h101, 16'h00DE, "poke_w1");
        fetch(10'h300, 16'h0000, "poke_not_300");

        // Reset in the middle of word 2
        pq = '{8'h12, 8'h34, 8'h56, 8'h78};
        pgm_session(10'h180, 1'b0, 3, 1'b0, 1'b0, 10'h000);
        rst = 1'b1;
        tick();
        chk1("midrst_busy", busy, 1'b0);
        chk16("midrst_do", do_w, 16'h0000);
        chk1("midrst_do_valid", do_valid, 1'b0);
        chk1("midrst_ready", pgm_ready, 1'b0);
        chk1("midrst_done", pgm_done, 1'b0);
        rst = 1'b0;
        last_do = 16'h0000;
        tick();
        fetch(10'h180, 16'h3412, "midrst_w1");
        fetch(10'h181, 16'h0000, "midrst_w2");

        // Random 8-byte sessions with a toggling PGM_VALID
        for (int s = 0; s < 4; s++) begin
            logic [9:0] b;
            b = 10'($urandom_range(0, 1023));
            pq = {};
            for (int i = 0; i < 8; i++) pq.push_back(8'($urandom_range(0, 255)));
            pgm_session(b, 1'b1, 0, 1'b0, 1'b0, 10'h000);
            for (int w = 0; w < 4; w++) fetch(10'(int'(b) + w), mem_m[10'(int'(b) + w)], "rnd8");
        end

        // Random-length sessions, then a random fetch stream
        for (int s = 0; s < 6; s++) begin
            int len;
            len = $urandom_range(1, 7);
            pq = {};
            for (int i = 0; i < len; i++) pq.push_back(8'($urandom_range(0, 255)));
            pgm_session(10'($urandom_range(0, 1023)), 1'b1, 0, 1'b0, 1'b0, 10'h000);
        end
        fetch_stream(200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
